// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer y = act(W*x + b); N_OUT saturating MACs, one x element per cycle.
// Latency: start edge E0 -> y/valid at edge E(N_IN+1); N_IN+2 cycles per vector.
// Backpressure: ready=0 while busy; start during busy is dropped, never queued.
module dense_layer_seq #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 2,
  parameter int ACT     = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          ready,
  input  logic [BITSIZE*N_IN-1:0]       x,
  input  logic [BITSIZE*N_OUT*N_IN-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic [BITSIZE*N_OUT-1:0]      y,
  output logic                          valid
);

  localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [JW-1:0]        r_j;
  logic [BITSIZE-1:0]   r_x   [N_IN];
  logic [BITSIZE-1:0]   r_acc [N_OUT];
  logic [BITSIZE-1:0]   r_y   [N_OUT];
  logic                 r_valid;
  logic                 w_last;
  logic [BITSIZE-1:0]   w_xj;
  logic [BITSIZE-1:0]   w_wt      [N_IN][N_OUT];
  logic [BITSIZE-1:0]   w_acc_nxt [N_OUT];
  logic [BITSIZE-1:0]   w_y_nxt   [N_OUT];

  // Clamp a double-width signed value into BITSIZE bits: in range iff the top BITSIZE+1 bits agree.
  function automatic logic [BITSIZE-1:0] sat(input logic [2*BITSIZE-1:0] v);
    if ((&v[2*BITSIZE-1:BITSIZE-1]) || ~(|v[2*BITSIZE-1:BITSIZE-1]))
      sat = v[BITSIZE-1:0];
    else if (v[2*BITSIZE-1])
      sat = {1'b1, {(BITSIZE-1){1'b0}}};
    else
      sat = {1'b0, {(BITSIZE-1){1'b1}}};
  endfunction

  assign ready  = (r_state == S_IDLE);
  assign valid  = r_valid;
  assign w_last = (r_j == JW'(N_IN - 1));
  assign w_xj   = r_x[r_j];

  genvar gi, go;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_wi
      for (go = 0; go < N_OUT; go++) begin : g_wo
        assign w_wt[gi][go] = w[BITSIZE*N_OUT*gi + BITSIZE*go +: BITSIZE];
      end
    end

    for (go = 0; go < N_OUT; go++) begin : g_mac
      logic signed [2*BITSIZE-1:0] w_xe;
      logic signed [2*BITSIZE-1:0] w_we;
      logic signed [2*BITSIZE-1:0] w_prod;
      logic signed [2*BITSIZE-1:0] w_shift;
      logic        [BITSIZE-1:0]   w_p;
      logic        [2*BITSIZE-1:0] w_sum;

      assign w_xe    = {{BITSIZE{w_xj[BITSIZE-1]}}, w_xj};
      assign w_we    = {{BITSIZE{w_wt[r_j][go][BITSIZE-1]}}, w_wt[r_j][go]};
      assign w_prod  = w_xe * w_we;
      assign w_shift = w_prod >>> FRAC;
      assign w_p     = sat(w_shift);
      assign w_sum   = {{BITSIZE{r_acc[go][BITSIZE-1]}}, r_acc[go]}
                     + {{BITSIZE{w_p[BITSIZE-1]}}, w_p};
      assign w_acc_nxt[go] = sat(w_sum);
      assign w_y_nxt[go]   = ((ACT == 1) && r_acc[go][BITSIZE-1]) ? '0 : r_acc[go];
      assign y[BITSIZE*go +: BITSIZE] = r_y[go];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start)  w_state_nxt = S_ACCUM;
      S_ACCUM:  if (w_last) w_state_nxt = S_OUTPUT;
      S_OUTPUT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_j     <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < N_IN; i++)  r_x[i]   <= '0;
      for (int o = 0; o < N_OUT; o++) r_acc[o] <= '0;
      for (int o = 0; o < N_OUT; o++) r_y[o]   <= '0;
    end else begin
      r_valid <= (r_state == S_OUTPUT);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_j <= '0;
            for (int i = 0; i < N_IN; i++)  r_x[i]   <= x[BITSIZE*i +: BITSIZE];
            for (int o = 0; o < N_OUT; o++) r_acc[o] <= b[BITSIZE*o +: BITSIZE];
          end
        end
        S_ACCUM: begin
          r_j <= w_last ? '0 : r_j + JW'(1);
          for (int o = 0; o < N_OUT; o++) r_acc[o] <= w_acc_nxt[o];
        end
        S_OUTPUT: begin
          for (int o = 0; o < N_OUT; o++) r_y[o] <= w_y_nxt[o];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: identity and ReLU instances share all inputs.
module tb_dense_layer_seq;
  localparam int BW = 16;
  localparam int NI = 6;
  localparam int NO = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [BW*NI-1:0]    x;
  logic [BW*NO*NI-1:0] w;
  logic [BW*NO-1:0]    b;
  logic              ready_a, valid_a, ready_r, valid_r;
  logic [BW*NO-1:0]    y_a, y_r;
  logic [31:0]       prev_a, prev_r;
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  dense_layer_seq #(.BITSIZE(BW), .FRAC(8), .N_IN(NI), .N_OUT(NO), .ACT(0)) u_lin (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready_a),
    .x(x), .w(w), .b(b), .y(y_a), .valid(valid_a)
  );

  dense_layer_seq #(.BITSIZE(BW), .FRAC(8), .N_IN(NI), .N_OUT(NO), .ACT(1)) u_relu (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready_r),
    .x(x), .w(w), .b(b), .y(y_r), .valid(valid_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return {28'b0, ready_a, valid_a, ready_r, valid_r};
  endfunction

  task automatic set_uniform(input logic [15:0] xv, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] b0, input logic [15:0] b1);
    x = {NI{xv}};
    w = {NI{w1, w0}};
    b = {b1, b0};
  endtask

  // One full transaction: start at E0, busy E0..E6, result at E7, idle at E8.
  task automatic run_vec(input string tag, input logic [31:0] ea, input logic [31:0] er);
    start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      start = 1'b0;
      if (k < 7) begin
        chk({tag, ":busy_flags"}, flags(), 32'h0);
        chk({tag, ":hold_y_lin"}, y_a, prev_a);
        chk({tag, ":hold_y_relu"}, y_r, prev_r);
      end else if (k == 7) begin
        chk({tag, ":done_flags"}, flags(), 32'hF);
        chk({tag, ":y_lin"}, y_a, ea);
        chk({tag, ":y_relu"}, y_r, er);
      end else begin
        chk({tag, ":idle_flags"}, flags(), 32'hA);
      end
    end
    prev_a = ea;
    prev_r = er;
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    set_uniform(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    prev_a = 32'h0;
    prev_r = 32'h0;
    #2 reset_n = 1'b0;
    #10;
    chk("reset:flags", flags(), 32'hA);
    chk("reset:y_lin", y_a, 32'h0);
    chk("reset:y_relu", y_r, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    set_uniform(16'h0100, 16'h0080, 16'h0080, 16'h0000, 16'h0000);
    run_vec("basic", 32'h0300_0300, 32'h0300_0300);

    set_uniform(16'h0100, 16'hFF80, 16'h0080, 16'hFF00, 16'h0100);
    run_vec("relu", 32'h0400_FC00, 32'h0400_0000);

    set_uniform(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
    run_vec("satpos", 32'h7FFF_7FFF, 32'h7FFF_7FFF);

    set_uniform(16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
    run_vec("satneg", 32'h8000_8000, 32'h0000_0000);

    // -1/256 per product truncates toward -inf to -1 LSB each.
    set_uniform(16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0005);
    run_vec("trunc", 32'h0005_FFFA, 32'h0005_0000);

    // Distinct x and W per index: y0 = 1+..+6 = 21.0, y1 = 1.0*2.0 + 6.0*0.5 = 5.0.
    b = 32'h0;
    for (int i = 0; i < NI; i++) begin
      x[BW*i +: BW]        = 16'((i + 1) * 256);
      w[BW*NO*i +: BW]      = 16'h0100;
      w[BW*NO*i + BW +: BW] = (i == 0) ? 16'h0200 : ((i == 5) ? 16'h0080 : 16'h0000);
    end
    run_vec("index", 32'h0500_1500, 32'h0500_1500);

    // start held high: accepted at E0 and E8, results at E7 and E15.
    set_uniform(16'h0100, 16'h0080, 16'h0080, 16'h0000, 16'h0000);
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 15) start = 1'b0;
      chk("stream:flags", flags(), (k % 8 == 7) ? 32'hF : 32'h0);
      chk("stream:y_lin", y_a, (k >= 7) ? 32'h0300_0300 : 32'h0500_1500);
    end
    prev_a = 32'h0300_0300;
    prev_r = 32'h0300_0300;

    // Busy start at E3 ignored; x changed after E0 ignored.
    set_uniform(16'h0100, 16'h0080, 16'h0080, 16'h0100, 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    x = {NI{16'h7FFF}};
    chk("ignore:e0_flags", flags(), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      start = (k == 3);
      tick();
      start = 1'b0;
      chk("ignore:flags", flags(), (k == 7) ? 32'hF : ((k >= 8) ? 32'hA : 32'h0));
      chk("ignore:y_lin", y_a, (k >= 7) ? 32'h0300_0400 : prev_a);
      chk("ignore:y_relu", y_r, (k >= 7) ? 32'h0300_0400 : prev_r);
    end

    // Reset asserted after E4 aborts the computation.
    set_uniform(16'h0100, 16'h0080, 16'h0080, 16'h0000, 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    reset_n = 1'b0;
    #1;
    chk("abort:flags", flags(), 32'hA);
    chk("abort:y_lin", y_a, 32'h0);
    chk("abort:y_relu", y_r, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("abort:after_flags", flags(), 32'hA);
      chk("abort:after_y", y_a, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
